// File: rtl/apb_master_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_cmd_bridge
// Brief    : Valid/ready command stream to single APB3/APB4 transfers, with a
//            valid/ready response stream. Optional ACCESS-phase watchdog is
//            enabled by defining APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master_cmd_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_pwrite,
    input  logic [ADDR_WIDTH-1:0] cmd_paddr,
    input  logic [DATA_WIDTH-1:0] cmd_pwdata,
    input  logic [STRB_WIDTH-1:0] cmd_pstrb,
    input  logic [2:0]            cmd_pprot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_prdata,
    output logic                  rsp_pslverr,
    output logic                  rsp_timeout,
    output logic                  m_apb_psel,
    output logic                  m_apb_penable,
    output logic                  m_apb_pwrite,
    output logic [2:0]            m_apb_pprot,
    output logic [ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [DATA_WIDTH-1:0] m_apb_pwdata,
    output logic [STRB_WIDTH-1:0] m_apb_pstrb,
    input  logic                  m_apb_pready,
    input  logic                  m_apb_pslverr,
    input  logic [DATA_WIDTH-1:0] m_apb_prdata,
    output logic                  busy
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  w_cmd_fire;
    logic                  w_abort;

    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic [2:0]            r_pprot;

    logic [DATA_WIDTH-1:0] r_rsp_prdata;
    logic                  r_rsp_pslverr;

    assign w_cmd_fire = cmd_valid && (r_state == c_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int                CW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]     c_WDOG_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0]     c_WDOG_ONE  = CW'(1);

    logic [CW-1:0] r_wdog;
    logic          r_rsp_timeout;

    // Completion wins over abort when pready arrives in the final wait cycle.
    assign w_abort = (r_state == c_ACCESS) && !m_apb_pready && (r_wdog == c_WDOG_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wdog        <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == c_SETUP) begin
                r_wdog <= '0;
            end else if ((r_state == c_ACCESS) && !m_apb_pready && !w_abort) begin
                r_wdog <= r_wdog + c_WDOG_ONE;
            end
            if (r_state == c_ACCESS) begin
                if (m_apb_pready) begin
                    r_rsp_timeout <= 1'b0;
                end else if (w_abort) begin
                    r_rsp_timeout <= 1'b1;
                end
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_abort     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (cmd_valid) w_state_nxt = c_SETUP;
            c_SETUP:  w_state_nxt = c_ACCESS;
            c_ACCESS: if (m_apb_pready || w_abort) w_state_nxt = c_RESP;
            c_RESP:   if (rsp_ready) w_state_nxt = c_IDLE;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state       <= c_IDLE;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
            r_rsp_prdata  <= '0;
            r_rsp_pslverr <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_pwrite <= cmd_pwrite;
                r_paddr  <= cmd_paddr;
                r_pwdata <= cmd_pwdata;
                r_pstrb  <= cmd_pwrite ? cmd_pstrb : '0;
                r_pprot  <= cmd_pprot;
            end
            if (r_state == c_ACCESS) begin
                if (m_apb_pready) begin
                    r_rsp_prdata  <= r_pwrite ? '0 : m_apb_prdata;
                    r_rsp_pslverr <= m_apb_pslverr;
                end else if (w_abort) begin
                    r_rsp_prdata  <= '0;
                    r_rsp_pslverr <= 1'b1;
                end
            end
        end
    end

    // Held low while reset is asserted so no command is taken during reset.
    assign cmd_ready     = (r_state == c_IDLE) && !preset;
    assign busy          = (r_state != c_IDLE);
    assign rsp_valid     = (r_state == c_RESP);
    assign rsp_prdata    = r_rsp_prdata;
    assign rsp_pslverr   = r_rsp_pslverr;

    assign m_apb_psel    = (r_state == c_SETUP) || (r_state == c_ACCESS);
    assign m_apb_penable = (r_state == c_ACCESS);
    assign m_apb_pwrite  = r_pwrite;
    assign m_apb_paddr   = r_paddr;
    assign m_apb_pwdata  = r_pwdata;
    assign m_apb_pstrb   = r_pstrb;
    assign m_apb_pprot   = r_pprot;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_cmd_bridge
// Brief    : Directed and randomised checks of apb_master_cmd_bridge; the
//            watchdog scenario follows APB_MASTER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_master_cmd_bridge;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_pwrite;
    logic [31:0] cmd_paddr;
    logic [31:0] cmd_pwdata;
    logic [3:0]  cmd_pstrb;
    logic [2:0]  cmd_pprot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_prdata;
    logic        rsp_pslverr;
    logic        rsp_timeout;
    logic        psel, penable, pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_cmd_bridge #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .STRB_WIDTH    (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .pclk         (pclk),
        .preset       (preset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_pwrite   (cmd_pwrite),
        .cmd_paddr    (cmd_paddr),
        .cmd_pwdata   (cmd_pwdata),
        .cmd_pstrb    (cmd_pstrb),
        .cmd_pprot    (cmd_pprot),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_prdata   (rsp_prdata),
        .rsp_pslverr  (rsp_pslverr),
        .rsp_timeout  (rsp_timeout),
        .m_apb_psel   (psel),
        .m_apb_penable(penable),
        .m_apb_pwrite (pwrite),
        .m_apb_pprot  (pprot),
        .m_apb_paddr  (paddr),
        .m_apb_pwdata (pwdata),
        .m_apb_pstrb  (pstrb),
        .m_apb_pready (pready),
        .m_apb_pslverr(pslverr),
        .m_apb_prdata (prdata),
        .busy         (busy)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [2:0] p);
        cmd_pwrite = w;
        cmd_paddr  = a;
        cmd_pwdata = d;
        cmd_pstrb  = s;
        cmd_pprot  = p;
        cmd_valid  = 1'b1;
    endtask

    task automatic test_reset();
        preset = 1'b1;
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        cmd_pwrite = 1'b0; cmd_paddr = '0; cmd_pwdata = '0; cmd_pstrb = '0; cmd_pprot = '0;
        tick();
        tick();
        n_checks++;
        if ({psel, penable, rsp_valid, cmd_ready, busy} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {psel, penable, rsp_valid, cmd_ready, busy});
        end
        n_checks++;
        if ({paddr, pwdata, pstrb, pwrite, pprot} !== 72'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h expected 0", {paddr, pwdata, pstrb, pwrite, pprot});
        end
        n_checks++;
        if ({rsp_prdata, rsp_pslverr, rsp_timeout} !== 34'h0) begin
            n_fail++;
            $display("FAIL reset_rsp: got %h expected 0", {rsp_prdata, rsp_pslverr, rsp_timeout});
        end
        preset = 1'b0;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        send_cmd(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'b010);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({psel, penable, cmd_ready, busy} !== 4'b1001) begin
            n_fail++;
            $display("FAIL wr_setup_ctrl: got %b expected 1001", {psel, penable, cmd_ready, busy});
        end
        n_checks++;
        if ({paddr, pwrite, pwdata, pstrb, pprot} !== {32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010}) begin
            n_fail++;
            $display("FAIL wr_setup_bus: got %h expected %h", {paddr, pwrite, pwdata, pstrb, pprot},
                     {32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010});
        end
        tick();
        n_checks++;
        if ({psel, penable} !== 2'b11) begin
            n_fail++;
            $display("FAIL wr_access: got %b expected 11", {psel, penable});
        end
        pready = 1'b1;
        prdata = 32'hAAAA_5555;
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, psel, penable, cmd_ready} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_resp_ctrl: got %b expected 1000", {rsp_valid, psel, penable, cmd_ready});
        end
        n_checks++;
        if ({rsp_prdata, rsp_pslverr, rsp_timeout} !== 34'h0) begin
            n_fail++;
            $display("FAIL wr_resp_data: got %h expected 0", {rsp_prdata, rsp_pslverr, rsp_timeout});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, cmd_ready, busy, paddr} !== {3'b010, 32'h0000_1000}) begin
            n_fail++;
            $display("FAIL wr_idle_hold: got %h expected %h", {rsp_valid, cmd_ready, busy, paddr},
                     {3'b010, 32'h0000_1000});
        end
    endtask

    task automatic test_read_wait();
        int pen_cnt;
        int addr_bad;
        pen_cnt = 0;
        addr_bad = 0;
        send_cmd(1'b0, 32'h0000_2004, 32'h5555_5555, 4'hF, 3'b000);
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({pwrite, pstrb} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rd_strb_zero: got %b expected 00000", {pwrite, pstrb});
        end
        tick();
        for (int i = 1; i <= 4; i++) begin
            if (penable === 1'b1) pen_cnt++;
            if (paddr !== 32'h0000_2004) addr_bad++;
            if (i == 4) begin
                pready = 1'b1;
                prdata = 32'h1234_5678;
            end
            tick();
        end
        pready = 1'b0;
        prdata = '0;
        n_checks++;
        if (pen_cnt != 4) begin
            n_fail++;
            $display("FAIL rd_penable_cycles: got %0d expected 4", pen_cnt);
        end
        n_checks++;
        if (addr_bad != 0) begin
            n_fail++;
            $display("FAIL rd_addr_stable: got %0d bad cycles expected 0", addr_bad);
        end
        n_checks++;
        if ({rsp_valid, rsp_prdata, rsp_pslverr, rsp_timeout} !== {1'b1, 32'h1234_5678, 2'b00}) begin
            n_fail++;
            $display("FAIL rd_resp: got %h expected %h", {rsp_valid, rsp_prdata, rsp_pslverr, rsp_timeout},
                     {1'b1, 32'h1234_5678, 2'b00});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_error_hold();
        send_cmd(1'b1, 32'h0000_3000, 32'h0F0F_0F0F, 4'h3, 3'b001);
        tick();
        cmd_valid = 1'b0;
        tick();
        pready = 1'b1;
        pslverr = 1'b1;
        tick();
        pready = 1'b0;
        pslverr = 1'b0;
        send_cmd(1'b0, 32'h0000_3008, 32'h0, 4'h0, 3'b000);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({rsp_valid, rsp_pslverr, rsp_prdata, cmd_ready, psel} !== {2'b11, 32'h0, 2'b00}) begin
                n_fail++;
                $display("FAIL err_hold[%0d]: got %h expected %h", i,
                         {rsp_valid, rsp_pslverr, rsp_prdata, cmd_ready, psel}, {2'b11, 32'h0, 2'b00});
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL err_release: got %b expected 10", {cmd_ready, rsp_valid});
        end
        tick();
        cmd_valid = 1'b0;
        n_checks++;
        if ({psel, penable, paddr} !== {2'b10, 32'h0000_3008}) begin
            n_fail++;
            $display("FAIL err_next_cmd: got %h expected %h", {psel, penable, paddr}, {2'b10, 32'h0000_3008});
        end
        tick();
        pready = 1'b1;
        prdata = 32'h00C0_FFEE;
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_prdata, rsp_pslverr} !== {1'b1, 32'h00C0_FFEE, 1'b0}) begin
            n_fail++;
            $display("FAIL err_next_resp: got %h expected %h", {rsp_valid, rsp_prdata, rsp_pslverr},
                     {1'b1, 32'h00C0_FFEE, 1'b0});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int acc;
`ifdef APB_MASTER_TIMEOUT_EN
        for (int rep = 0; rep < 2; rep++) begin
            acc = 0;
            send_cmd(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000);
            tick();
            cmd_valid = 1'b0;
            prdata = 32'hFFFF_FFFF;
            tick();
            for (int i = 1; i <= 8; i++) begin
                if (penable === 1'b1) acc++;
                if (i == 8 && rep == 1) begin
                    pready = 1'b1;
                    prdata = 32'hCAFE_F00D;
                end
                if (i < 8) tick();
            end
            tick();
            pready = 1'b0;
            n_checks++;
            if (acc != 8) begin
                n_fail++;
                $display("FAIL to_access_cycles[%0d]: got %0d expected 8", rep, acc);
            end
            n_checks++;
            if (rep == 0) begin
                if ({psel, penable, rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata} !== {5'b00111, 32'h0}) begin
                    n_fail++;
                    $display("FAIL to_abort: got %h expected %h",
                             {psel, penable, rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata}, {5'b00111, 32'h0});
                end
            end else begin
                if ({psel, penable, rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata} !== {5'b00100, 32'hCAFE_F00D}) begin
                    n_fail++;
                    $display("FAIL to_late_ready: got %h expected %h",
                             {psel, penable, rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata},
                             {5'b00100, 32'hCAFE_F00D});
                end
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
`else
        acc = 0;
        send_cmd(1'b0, 32'h0000_4000, 32'h0, 4'h0, 3'b000);
        tick();
        cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            if ({psel, penable} === 2'b11) acc++;
            tick();
        end
        n_checks++;
        if (acc != 20 || {psel, penable} !== 2'b11) begin
            n_fail++;
            $display("FAIL stall_no_abort: got %0d access cycles expected 20", acc);
        end
        pready = 1'b1;
        prdata = 32'hCAFE_F00D;
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata} !== {3'b100, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL stall_resp: got %h expected %h", {rsp_valid, rsp_pslverr, rsp_timeout, rsp_prdata},
                     {3'b100, 32'hCAFE_F00D});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
    endtask

    task automatic test_reset_mid();
        send_cmd(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b000);
        tick();
        cmd_valid = 1'b0;
        tick();
        preset = 1'b1;
        tick();
        n_checks++;
        if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL rst_mid: got %b expected 00000", {psel, penable, rsp_valid, busy, cmd_ready});
        end
        preset = 1'b0;
        send_cmd(1'b0, 32'h0000_2008, 32'h0, 4'h0, 3'b000);
        tick();
        cmd_valid = 1'b0;
        tick();
        pready = 1'b1;
        prdata = 32'h0BAD_C0DE;
        tick();
        pready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_prdata, rsp_pslverr, rsp_timeout} !== {1'b1, 32'h0BAD_C0DE, 2'b00}) begin
            n_fail++;
            $display("FAIL rst_fresh_read: got %h expected %h", {rsp_valid, rsp_prdata, rsp_pslverr, rsp_timeout},
                     {1'b1, 32'h0BAD_C0DE, 2'b00});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] slv_mem [16];
        logic [31:0] ref_mem [16];
        logic [31:0] exp_q [$];
        logic [31:0] exp_v;
        logic [31:0] setup_addr;
        logic [3:0]  idx;
        logic        fire_pend;
        logic        acc_pend;
        int issued, got, cyc, gap, wait_left;
        issued = 0; got = 0; cyc = 0; gap = 0; wait_left = 0;
        fire_pend = 1'b0; acc_pend = 1'b0; setup_addr = '0;
        for (int i = 0; i < 16; i++) begin
            slv_mem[i] = (32'h0101_0101 * i) ^ 32'hA5A5_A5A5;
            ref_mem[i] = slv_mem[i];
        end
        while (got < 100 && cyc < 6000) begin
            if (fire_pend) begin
                cmd_valid = 1'b0;
                gap = $urandom_range(0, 3);
                fire_pend = 1'b0;
            end
            if (acc_pend) begin
                n_checks++;
                if ({psel, penable} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL b2b_psel_hold: got %b expected 11 at cycle %0d", {psel, penable}, cyc);
                end
            end
            if (!cmd_valid && issued < 100) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    send_cmd(1'($urandom_range(0, 1)), 32'h0000_8000 | 32'($urandom_range(0, 15) << 2),
                             $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
                    issued++;
                end
            end
            n_checks++;
            if (cmd_ready && rsp_valid) begin
                n_fail++;
                $display("FAIL b2b_ready_vs_valid: got cmd_ready=1 rsp_valid=1 expected not both at cycle %0d", cyc);
            end
            pready = 1'b0;
            pslverr = 1'b0;
            prdata = $urandom;
            if (psel && !penable) begin
                wait_left = $urandom_range(0, 3);
                setup_addr = paddr;
            end else if (psel && penable) begin
                n_checks++;
                if (paddr !== setup_addr) begin
                    n_fail++;
                    $display("FAIL b2b_addr_stable: got %h expected %h", paddr, setup_addr);
                end
                if (wait_left == 0) begin
                    pready = 1'b1;
                    idx = paddr[5:2];
                    if (pwrite) begin
                        for (int b = 0; b < 4; b++)
                            if (pstrb[b]) slv_mem[idx][8*b +: 8] = pwdata[8*b +: 8];
                    end else begin
                        prdata = slv_mem[idx];
                    end
                end else begin
                    wait_left--;
                end
            end
            acc_pend = psel && penable && !pready;
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (rsp_valid && rsp_ready) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
                n_checks++;
                if ({rsp_prdata, rsp_pslverr, rsp_timeout} !== {exp_v, 2'b00}) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: got %h expected %h", got,
                             {rsp_prdata, rsp_pslverr, rsp_timeout}, {exp_v, 2'b00});
                end
                got++;
            end
            if (cmd_valid && cmd_ready) begin
                idx = cmd_paddr[5:2];
                if (cmd_pwrite) begin
                    for (int b = 0; b < 4; b++)
                        if (cmd_pstrb[b]) ref_mem[idx][8*b +: 8] = cmd_pwdata[8*b +: 8];
                    exp_q.push_back(32'h0);
                end else begin
                    exp_q.push_back(ref_mem[idx]);
                end
                fire_pend = 1'b1;
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        pready = 1'b0;
        n_checks++;
        if (got != 100) begin
            n_fail++;
            $display("FAIL b2b_completion: got %0d responses expected 100 within cycle budget", got);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_error_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
